// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing generator and pattern engine.
// Holds pattern mode encodings and the line/frame total helper.
package vga_pkg;

    localparam logic [2:0] MODE_SOLID  = 3'd0;
    localparam logic [2:0] MODE_VBAR   = 3'd1;
    localparam logic [2:0] MODE_HBAR   = 3'd2;
    localparam logic [2:0] MODE_CHECK  = 3'd3;
    localparam logic [2:0] MODE_GRAD   = 3'd4;
    localparam logic [2:0] MODE_SCROLL = 3'd5;

    function automatic int calc_total(
        input int disp,
        input int fp,
        input int sync,
        input int bp
    );
        return disp + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_core.sv
// VGA h/v counters with raw (active-high, unregistered) sync and display enable.
// Ports: clk, reset (async, active-high); h_cnt/v_cnt counters;
//        hsync_raw/vsync_raw/de_raw decoded from the counters; frame_end on the last pixel of a frame.
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int H_DISP = 800,
    parameter int H_FP   = 56,
    parameter int H_SYNC = 120,
    parameter int H_BP   = 64,
    parameter int V_DISP = 600,
    parameter int V_FP   = 37,
    parameter int V_SYNC = 6,
    parameter int V_BP   = 23,
    parameter int CNT_W  = 11
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             hsync_raw,
    output logic             vsync_raw,
    output logic             de_raw,
    output logic             frame_end
);

    localparam int H_TOTAL = calc_total(H_DISP, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_DISP, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_DE   = CNT_W'(H_DISP);
    localparam logic [CNT_W-1:0] V_DE   = CNT_W'(V_DISP);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_DISP + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_DISP + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_DISP + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_DISP + V_FP + V_SYNC);

    logic w_h_wrap;
    logic w_v_wrap;

    assign w_h_wrap = (h_cnt == H_LAST);
    assign w_v_wrap = (v_cnt == V_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (w_h_wrap) begin
            h_cnt <= '0;
            if (w_v_wrap) v_cnt <= '0;
            else          v_cnt <= v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign hsync_raw = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vsync_raw = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign de_raw    = (h_cnt < H_DE) && (v_cnt < V_DE);
    assign frame_end = w_h_wrap && w_v_wrap;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing generator with frame-synchronous test-pattern engine.
// Ports: clk, reset (async, active-high); mode/color_a/color_b sampled at frame end;
//        hsync/vsync/video_on/rgb/pixel_x/pixel_y/frame_start registered, 2-cycle latency.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_DISP      = 800,
    parameter int H_FP        = 56,
    parameter int H_SYNC      = 120,
    parameter int H_BP        = 64,
    parameter int V_DISP      = 600,
    parameter int V_FP        = 37,
    parameter int V_SYNC      = 6,
    parameter int V_BP        = 23,
    parameter bit HS_POL      = 1'b1,
    parameter bit VS_POL      = 1'b1,
    parameter int CNT_W       = 11,
    parameter int COLOR_W     = 8,
    parameter int BAR_W       = 100,
    parameter int SCROLL_STEP = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         mode,
    input  logic [COLOR_W-1:0] color_a,
    input  logic [COLOR_W-1:0] color_b,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [COLOR_W-1:0] rgb,
    output logic [CNT_W-1:0]   pixel_x,
    output logic [CNT_W-1:0]   pixel_y,
    output logic               frame_start
);

    localparam int RUN_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int SCR_W = $clog2(2 * BAR_W);
    localparam int H_TOT = calc_total(H_DISP, H_FP, H_SYNC, H_BP);

    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(BAR_W - 1);
    localparam logic [SCR_W:0]   SCR_N    = (SCR_W+1)'(BAR_W);
    localparam logic [SCR_W:0]   SCR_2N   = (SCR_W+1)'(2 * BAR_W);
    localparam logic [SCR_W:0]   SCR_STEP = (SCR_W+1)'(SCROLL_STEP);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);

    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_hs_raw;
    logic             w_vs_raw;
    logic             w_de_raw;
    logic             w_frame_end;

    vga_timing_core #(
        .H_DISP (H_DISP),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_DISP (V_DISP),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP),
        .CNT_W  (CNT_W)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .h_cnt     (w_h_cnt),
        .v_cnt     (w_v_cnt),
        .hsync_raw (w_hs_raw),
        .vsync_raw (w_vs_raw),
        .de_raw    (w_de_raw),
        .frame_end (w_frame_end)
    );

    logic               w_h_wrap;
    logic [2:0]         r_mode;
    logic [COLOR_W-1:0] r_color_a;
    logic [COLOR_W-1:0] r_color_b;
    logic [SCR_W:0]     r_scroll;
    logic [SCR_W:0]     w_scroll_sum;
    logic [SCR_W:0]     w_scroll_nxt;

    assign w_h_wrap     = (w_h_cnt == H_LAST);
    assign w_scroll_sum = r_scroll + SCR_STEP;
    assign w_scroll_nxt = (w_scroll_sum >= SCR_2N) ? w_scroll_sum - SCR_2N : w_scroll_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode    <= MODE_SOLID;
            r_color_a <= '0;
            r_color_b <= '0;
            r_scroll  <= '0;
        end else if (w_frame_end) begin
            r_mode    <= mode;
            r_color_a <= color_a;
            r_color_b <= color_b;
            r_scroll  <= w_scroll_nxt;
        end
    end

    // Line-start preload of the x run counter. On the frame boundary the
    // new line belongs to the next frame, so use the values about to latch.
    logic [2:0]       w_pre_mode;
    logic [SCR_W:0]   w_pre_scroll;
    logic [RUN_W-1:0] w_pre_run;
    logic             w_pre_ph;

    assign w_pre_mode   = w_frame_end ? mode : r_mode;
    assign w_pre_scroll = w_frame_end ? w_scroll_nxt : r_scroll;

    always_comb begin
        w_pre_run = '0;
        w_pre_ph  = 1'b0;
        if (w_pre_mode == MODE_SCROLL) begin
            if (w_pre_scroll >= SCR_N) begin
                w_pre_ph  = 1'b1;
                w_pre_run = RUN_W'(w_pre_scroll - SCR_N);
            end else begin
                w_pre_run = RUN_W'(w_pre_scroll);
            end
        end
    end

    // Run counters track bar phase of the pixel/line the counters point at.
    logic [RUN_W-1:0] r_xrun;
    logic             r_xph;
    logic [RUN_W-1:0] r_yrun;
    logic             r_yph;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_xrun <= '0;
            r_xph  <= 1'b0;
        end else if (w_h_wrap) begin
            r_xrun <= w_pre_run;
            r_xph  <= w_pre_ph;
        end else if (r_xrun == RUN_LAST) begin
            r_xrun <= '0;
            r_xph  <= ~r_xph;
        end else begin
            r_xrun <= r_xrun + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_yrun <= '0;
            r_yph  <= 1'b0;
        end else if (w_h_wrap) begin
            if (w_frame_end) begin
                r_yrun <= '0;
                r_yph  <= 1'b0;
            end else if (r_yrun == RUN_LAST) begin
                r_yrun <= '0;
                r_yph  <= ~r_yph;
            end else begin
                r_yrun <= r_yrun + 1'b1;
            end
        end
    end

    logic [COLOR_W-1:0] w_grad;
    logic [COLOR_W-1:0] w_color;

    assign w_grad = COLOR_W'(w_h_cnt >> 3);

    always_comb begin
        w_color = '0;
        case (r_mode)
            MODE_SOLID:  w_color = r_color_a;
            MODE_VBAR,
            MODE_SCROLL: w_color = r_xph ? r_color_b : r_color_a;
            MODE_HBAR:   w_color = r_yph ? r_color_b : r_color_a;
            MODE_CHECK:  w_color = (r_xph ^ r_yph) ? r_color_b : r_color_a;
            MODE_GRAD:   w_color = w_grad;
            default:     w_color = '0;
        endcase
    end

    // Stage 1: decode from counters. Stage 2: output registers.
    logic               r1_de;
    logic               r1_hs;
    logic               r1_vs;
    logic               r1_fs;
    logic [CNT_W-1:0]   r1_x;
    logic [CNT_W-1:0]   r1_y;
    logic [COLOR_W-1:0] r1_rgb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r1_de  <= 1'b0;
            r1_hs  <= 1'b0;
            r1_vs  <= 1'b0;
            r1_fs  <= 1'b0;
            r1_x   <= '0;
            r1_y   <= '0;
            r1_rgb <= '0;
        end else begin
            r1_de  <= w_de_raw;
            r1_hs  <= w_hs_raw;
            r1_vs  <= w_vs_raw;
            r1_fs  <= (w_h_cnt == '0) && (w_v_cnt == '0);
            r1_x   <= w_de_raw ? w_h_cnt : '0;
            r1_y   <= w_de_raw ? w_v_cnt : '0;
            r1_rgb <= w_de_raw ? w_color : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            rgb         <= '0;
        end else begin
            hsync       <= HS_POL ? r1_hs : ~r1_hs;
            vsync       <= VS_POL ? r1_vs : ~r1_vs;
            video_on    <= r1_de;
            frame_start <= r1_fs;
            pixel_x     <= r1_x;
            pixel_y     <= r1_y;
            rgb         <= r1_rgb;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen with small timing: model predicts every output
// from the linear pixel index since reset, plus literal pin-down checks.
module tb_vga_pattern_gen;

    localparam int HT = 23;
    localparam int VT = 12;
    localparam int FT = HT * VT;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [7:0]  color_a = 8'h00;
    logic [7:0]  color_b = 8'h00;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [7:0]  rgb;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic        frame_start;

    vga_pattern_gen #(
        .H_DISP (16), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_DISP (8),  .V_FP (1), .V_SYNC (2), .V_BP (1),
        .HS_POL (1'b1), .VS_POL (1'b1),
        .CNT_W (11), .COLOR_W (8), .BAR_W (4), .SCROLL_STEP (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .color_a     (color_a),
        .color_b     (color_b),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .rgb         (rgb),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // t = clock edges since reset release; inputs captured per frame.
    int         t = 0;
    logic [2:0] fm [64];
    logic [7:0] fa [64];
    logic [7:0] fb [64];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            t     <= 0;
            fm[0] <= 3'd0;
            fa[0] <= 8'h00;
            fb[0] <= 8'h00;
        end else begin
            if (t % FT == FT - 1) begin
                fm[(t / FT + 1) % 64] <= mode;
                fa[(t / FT + 1) % 64] <= color_a;
                fb[(t / FT + 1) % 64] <= color_b;
            end
            t <= t + 1;
        end
    end

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [7:0]  rgb;
        logic [10:0] x;
        logic [10:0] y;
    } exp_t;

    function automatic logic [7:0] pat(input int md, input logic [7:0] a,
                                       input logic [7:0] b, input int x,
                                       input int y, input int s);
        case (md)
            0: return a;
            1: return ((x / 4) % 2 == 1) ? b : a;
            2: return ((y / 4) % 2 == 1) ? b : a;
            3: return (((x / 4) + (y / 4)) % 2 == 1) ? b : a;
            4: return 8'((x / 8) % 256);
            5: return (((x + s) / 4) % 2 == 1) ? b : a;
            default: return 8'h00;
        endcase
    endfunction

    function automatic exp_t model(input int tt, input logic rst);
        exp_t e;
        int p, h, v, f, s;
        e = '0;
        if (!rst && tt >= 2) begin
            p = tt - 2;
            h = p % HT;
            v = (p / HT) % VT;
            f = p / FT;
            s = (2 * f) % 8;
            e.de = (h < 16) && (v < 8);
            e.hs = (h >= 18) && (h < 21);
            e.vs = (v >= 9) && (v < 11);
            e.fs = (h == 0) && (v == 0);
            e.x  = e.de ? 11'(h) : 11'd0;
            e.y  = e.de ? 11'(v) : 11'd0;
            e.rgb = e.de ? pat(int'(fm[f % 64]), fa[f % 64], fb[f % 64], h, v, s) : 8'h00;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s t=%0d actual=%0h expected=%0h", nm, t, act, exp_v);
    endtask

    task automatic compare_now();
        exp_t e;
        e = model(t, reset);
        chk("hsync", int'(hsync), int'(e.hs));
        chk("vsync", int'(vsync), int'(e.vs));
        chk("video_on", int'(video_on), int'(e.de));
        chk("frame_start", int'(frame_start), int'(e.fs));
        chk("rgb", int'(rgb), int'(e.rgb));
        chk("pixel_x", int'(pixel_x), int'(e.x));
        chk("pixel_y", int'(pixel_y), int'(e.y));
    endtask

    always @(negedge clk) compare_now();

    task automatic goto(input int target);
        int g;
        g = 0;
        while (t < target && g < 20000) begin
            @(negedge clk);
            g++;
        end
        if (t != target) chk("goto", t, target);
    endtask

    task automatic first_b(input int start, input int exp_x, input string nm);
        int fx;
        fx = -1;
        goto(start);
        for (int i = 0; i < 16; i++) begin
            if (fx < 0 && rgb == 8'hE0) fx = i;
            @(negedge clk);
        end
        chk(nm, fx, exp_x);
    endtask

    logic [7:0] l0 [16] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hE0, 8'hE0, 8'hE0, 8'hE0,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'hE0, 8'hE0, 8'hE0, 8'hE0};
    int         scr_x [5] = '{0, 0, 4, 2, 0};

    initial begin
        int hs_n, vs_n, de_n, fs_n, nhr, nvr, nfr;
        int hr [2];
        int vr [2];
        int fr [2];
        logic phs, pvs;
        hs_n = 0; vs_n = 0; de_n = 0; fs_n = 0;
        nhr = 0; nvr = 0; nfr = 0;
        hr = '{0, 0}; vr = '{0, 0}; fr = '{0, 0};
        phs = 1'b0; pvs = 1'b0;

        #1 reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_hsync", int'(hsync), 0);
        chk("rst_vsync", int'(vsync), 0);
        chk("rst_video_on", int'(video_on), 0);
        chk("rst_rgb", int'(rgb), 0);
        mode = 3'd1; color_a = 8'h00; color_b = 8'hE0;
        reset = 1'b0;

        goto(2);
        chk("first_fs", int'(frame_start), 1);
        chk("first_de", int'(video_on), 1);
        chk("frame0_black", int'(rgb), 0);
        for (int i = 0; i < 2 * FT; i++) begin
            if (hsync) hs_n++;
            if (vsync) vs_n++;
            if (video_on) de_n++;
            if (frame_start) begin
                fs_n++;
                if (nfr < 2) begin fr[nfr] = t; nfr++; end
            end
            if (hsync && !phs && nhr < 2) begin hr[nhr] = t; nhr++; end
            if (vsync && !pvs && nvr < 2) begin vr[nvr] = t; nvr++; end
            phs = hsync;
            pvs = vsync;
            if (t >= FT + 2 && t < FT + 18)
                chk("bar_line0", int'(rgb), int'(l0[t - FT - 2]));
            if (i == 400) mode = 3'd3;
            @(negedge clk);
        end
        chk("hsync_high_cnt", hs_n, 72);
        chk("vsync_high_cnt", vs_n, 92);
        chk("video_on_cnt", de_n, 256);
        chk("frame_start_cnt", fs_n, 2);
        chk("hsync_period", hr[1] - hr[0], 23);
        chk("vsync_period", vr[1] - vr[0], 276);
        chk("fs_period", fr[1] - fr[0], 276);

        chk("chk_l0_x0", int'(rgb), 8'h00);
        goto(558);
        chk("chk_l0_x4", int'(rgb), 8'hE0);
        goto(646);
        chk("chk_l4_x0", int'(rgb), 8'hE0);
        goto(700);
        mode = 3'd0; color_a = 8'h1C;
        goto(830);
        chk("solid_x0", int'(rgb), 8'h1C);
        goto(900);
        mode = 3'd1;
        goto(949);
        chk("midframe_hold", int'(rgb), 8'h1C);
        goto(1110);
        chk("next_frame_bar", int'(rgb), 8'hE0);
        goto(1200);
        mode = 3'd4;
        goto(1385);
        chk("grad_x3", int'(rgb), 8'h00);
        goto(1393);
        chk("grad_x11", int'(rgb), 8'h01);
        goto(1500);
        mode = 3'd5; color_a = 8'h00;
        for (int k = 0; k < 5; k++)
            first_b(6 * FT + k * FT + 2, scr_x[k], "scroll_edge");
        goto(2900);
        mode = 3'd6;
        goto(11 * FT + 2);
        chk("black_de", int'(video_on), 1);
        chk("black_rgb", int'(rgb), 0);

        goto(11 * FT + 5 * HT + 7);
        chk("pre_rst_x", int'(pixel_x), 5);
        chk("pre_rst_y", int'(pixel_y), 5);
        #2 reset = 1'b1;
        #1;
        chk("async_x", int'(pixel_x), 0);
        chk("async_y", int'(pixel_y), 0);
        chk("async_de", int'(video_on), 0);
        chk("async_hs", int'(hsync), 0);
        mode = 3'd1; color_a = 8'h00; color_b = 8'hE0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rel1_fs", int'(frame_start), 0);
        chk("rel1_de", int'(video_on), 0);
        @(negedge clk);
        chk("rel2_fs", int'(frame_start), 1);
        chk("rel2_de", int'(video_on), 1);
        chk("rel2_x", int'(pixel_x), 0);
        chk("rel2_rgb", int'(rgb), 0);
        goto(600);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
